// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised register file: function-select codes
// and the swap engine state encoding.
package reg_file_pkg;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;
    localparam logic [2:0] FS_LDLZ = 3'b100;
    localparam logic [2:0] FS_LDLK = 3'b101;
    localparam logic [2:0] FS_LDLS = 3'b110;
    localparam logic [2:0] FS_HOLD = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } swap_state_t;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit register implementing the FunSel operations, with an override
// load used by the swap engine that takes priority over the normal write.
module register_cell
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       fun_sel,
    input  logic             en,
    input  logic             ovr_en,
    input  logic [WIDTH-1:0] ovr_d,
    output logic [WIDTH-1:0] q
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;

    // Next-value selection: swap override first, then the function select
    always_comb begin
        next_s = q_r;
        if (ovr_en) begin
            next_s = ovr_d;
        end else if (en) begin
            case (fun_sel)
                FS_DEC:  next_s = q_r - WIDTH'(1);
                FS_INC:  next_s = q_r + WIDTH'(1);
                FS_LOAD: next_s = d;
                FS_CLR:  next_s = '0;
                FS_LDLZ: next_s = {{H{1'b0}}, d[H-1:0]};
                FS_LDLK: next_s = {q_r[WIDTH-1:H], d[H-1:0]};
                FS_LDLS: next_s = {{H{d[H-1]}}, d[H-1:0]};
                FS_HOLD: next_s = q_r;
                default: next_s = q_r;
            endcase
        end else begin
            next_s = q_r;
        end
    end

    // Register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: NUM_REGS cells on a shared write bus, two
// combinational read ports with optional LOAD bypass, and a two-cycle swap engine.
module param_register_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int BYPASS   = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    I,
    input  logic [2:0]          FunSel,
    input  logic [NUM_REGS-1:0] RegEn,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    input  logic                SwapValid,
    input  logic [SEL_W-1:0]    SwapASel,
    input  logic [SEL_W-1:0]    SwapBSel,
    output logic                SwapReady,
    output logic                SwapDone
);

    localparam bit BYP_EN = (BYPASS != 32'sd0);

    logic [WIDTH-1:0] q_s [NUM_REGS];
    logic [WIDTH-1:0] outa_s, outb_s, swapa_val_s, swapb_val_s;
    logic [WIDTH-1:0] tmpa_r, tmpb_r;
    logic [SEL_W-1:0] idxa_r, idxb_r;
    swap_state_t      state_r, state_nx_s;
    logic             capture_s, commit_s, ready_s, done_r;

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_cell
        logic             ovr_en_s;
        logic [WIDTH-1:0] ovr_d_s;

        // Swap targets take the other operand's temporary; a self-swap writes back its own value
        assign ovr_en_s = commit_s && ((idxa_r == SEL_W'(n)) || (idxb_r == SEL_W'(n)));
        assign ovr_d_s  = (idxa_r == SEL_W'(n)) ? tmpb_r : tmpa_r;

        register_cell #(.WIDTH(WIDTH)) u_cell (
            .clk     (Clock),
            .rst     (Reset),
            .d       (I),
            .fun_sel (FunSel),
            .en      (RegEn[n]),
            .ovr_en  (ovr_en_s),
            .ovr_d   (ovr_d_s),
            .q       (q_s[n])
        );
    end

    // Read and swap-operand muxes; out-of-range selects read as zero
    always_comb begin
        outa_s      = '0;
        outb_s      = '0;
        swapa_val_s = '0;
        swapb_val_s = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (OutASel == SEL_W'(n)) begin
                outa_s = (BYP_EN && (FunSel == FS_LOAD) && RegEn[n]) ? I : q_s[n];
            end else begin
                outa_s = outa_s;
            end
            if (OutBSel == SEL_W'(n)) begin
                outb_s = (BYP_EN && (FunSel == FS_LOAD) && RegEn[n]) ? I : q_s[n];
            end else begin
                outb_s = outb_s;
            end
            if (SwapASel == SEL_W'(n)) begin
                swapa_val_s = q_s[n];
            end else begin
                swapa_val_s = swapa_val_s;
            end
            if (SwapBSel == SEL_W'(n)) begin
                swapb_val_s = q_s[n];
            end else begin
                swapb_val_s = swapb_val_s;
            end
        end
    end

    // Swap FSM state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Swap FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:   state_nx_s = SwapValid ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Swap FSM outputs
    always_comb begin
        capture_s = 1'b0;
        commit_s  = 1'b0;
        ready_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s   = 1'b1;
                capture_s = SwapValid;
            end
            ST_COMMIT: commit_s = 1'b1;
            default:   ready_s  = 1'b0;
        endcase
    end

    // Swap operand and index capture
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tmpa_r <= '0;
            tmpb_r <= '0;
            idxa_r <= '0;
            idxb_r <= '0;
        end else if (capture_s) begin
            tmpa_r <= swapa_val_s;
            tmpb_r <= swapb_val_s;
            idxa_r <= SwapASel;
            idxb_r <= SwapBSel;
        end else begin
            tmpa_r <= tmpa_r;
            tmpb_r <= tmpb_r;
            idxa_r <= idxa_r;
            idxb_r <= idxb_r;
        end
    end

    // Completion pulse, high for the cycle after the commit edge
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= commit_s;
        end
    end

    assign OutA      = outa_s;
    assign OutB      = outb_s;
    assign SwapReady = ready_s;
    assign SwapDone  = done_r;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: dut0 is the default 8-register file without bypass, dut1 is a
// 6-register file with bypass, both driven from the same stimulus.
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [2:0]  fs;
    logic [7:0]  regen;
    logic [2:0]  asel, bsel, swa, swb;
    logic        swv;
    logic [31:0] outa0, outb0, outa1, outb1;
    logic        ready0, done0, ready1, done1;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    param_register_file #(.WIDTH(32), .NUM_REGS(8), .SEL_W(3), .BYPASS(0)) dut0 (
        .Clock(clk), .Reset(rst), .I(din), .FunSel(fs), .RegEn(regen),
        .OutASel(asel), .OutBSel(bsel), .OutA(outa0), .OutB(outb0),
        .SwapValid(swv), .SwapASel(swa), .SwapBSel(swb),
        .SwapReady(ready0), .SwapDone(done0)
    );

    param_register_file #(.WIDTH(32), .NUM_REGS(6), .SEL_W(3), .BYPASS(1)) dut1 (
        .Clock(clk), .Reset(rst), .I(din), .FunSel(fs), .RegEn(regen[5:0]),
        .OutASel(asel), .OutBSel(bsel), .OutA(outa1), .OutB(outb1),
        .SwapValid(swv), .SwapASel(swa), .SwapBSel(swb),
        .SwapReady(ready1), .SwapDone(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] en, input logic [2:0] f, input logic [31:0] d);
        regen = en; fs = f; din = d;
        tick();
        regen = 8'h00; fs = 3'b111; din = 32'h0;
    endtask

    task automatic sel(input logic [2:0] a, input logic [2:0] b);
        asel = a; bsel = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 32'h0; fs = 3'b111; regen = 8'h00;
        asel = 3'd0; bsel = 3'd1; swv = 1'b0; swa = 3'd0; swb = 3'd0;
        #12;
        total_cnt++; if (outa0 !== 32'h0) $display("FAIL reset_outa: got %h want %h", outa0, 32'h0); else pass_cnt++;
        total_cnt++; if (outb1 !== 32'h0) $display("FAIL reset_outb1: got %h want %h", outb1, 32'h0); else pass_cnt++;
        total_cnt++; if (ready0 !== 1'b1 || ready1 !== 1'b1) $display("FAIL reset_ready: got %b%b want 11", ready0, ready1); else pass_cnt++;
        total_cnt++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_bypass();
        regen = 8'h01; fs = 3'b010; din = 32'hDEADBEEF;
        sel(3'd0, 3'd0);
        total_cnt++; if (outa0 !== 32'h0) $display("FAIL nobyp_pre: got %h want %h", outa0, 32'h0); else pass_cnt++;
        total_cnt++; if (outa1 !== 32'hDEADBEEF) $display("FAIL byp_pre_a: got %h want %h", outa1, 32'hDEADBEEF); else pass_cnt++;
        total_cnt++; if (outb1 !== 32'hDEADBEEF) $display("FAIL byp_pre_b: got %h want %h", outb1, 32'hDEADBEEF); else pass_cnt++;
        tick();
        regen = 8'h00; fs = 3'b111; din = 32'h0;
        #1;
        total_cnt++; if (outa0 !== 32'hDEADBEEF) $display("FAIL load_post: got %h want %h", outa0, 32'hDEADBEEF); else pass_cnt++;
        total_cnt++; if (outa1 !== 32'hDEADBEEF) $display("FAIL byp_post: got %h want %h", outa1, 32'hDEADBEEF); else pass_cnt++;
        // CLR must not bypass: the old value stays visible until the edge
        regen = 8'h01; fs = 3'b011; din = 32'h12345678;
        #1;
        total_cnt++; if (outa1 !== 32'hDEADBEEF) $display("FAIL byp_clr: got %h want %h", outa1, 32'hDEADBEEF); else pass_cnt++;
        tick();
        regen = 8'h00; fs = 3'b111;
        #1;
        total_cnt++; if (outa0 !== 32'h0) $display("FAIL clr: got %h want %h", outa0, 32'h0); else pass_cnt++;
    endtask

    task automatic test_functions();
        op(8'h04, 3'b010, 32'hFFFFFFFF);
        op(8'h04, 3'b001, 32'h0);
        sel(3'd2, 3'd2);
        total_cnt++; if (outa0 !== 32'h00000000) $display("FAIL inc_wrap: got %h want %h", outa0, 32'h0); else pass_cnt++;
        op(8'h04, 3'b000, 32'h0);
        sel(3'd2, 3'd2);
        total_cnt++; if (outa0 !== 32'hFFFFFFFF) $display("FAIL dec_wrap: got %h want %h", outa0, 32'hFFFFFFFF); else pass_cnt++;
        op(8'h04, 3'b010, 32'h12345678);
        op(8'h04, 3'b110, 32'h00008001);
        sel(3'd2, 3'd2);
        total_cnt++; if (outa0 !== 32'hFFFF8001) $display("FAIL ldls: got %h want %h", outa0, 32'hFFFF8001); else pass_cnt++;
        op(8'h04, 3'b101, 32'h0000AAAA);
        sel(3'd2, 3'd2);
        total_cnt++; if (outa0 !== 32'hFFFFAAAA) $display("FAIL ldlk: got %h want %h", outa0, 32'hFFFFAAAA); else pass_cnt++;
        total_cnt++; if (outa1 !== 32'hFFFFAAAA) $display("FAIL ldlk_dut1: got %h want %h", outa1, 32'hFFFFAAAA); else pass_cnt++;
        op(8'h20, 3'b100, 32'h1234ABCD);
        sel(3'd5, 3'd5);
        total_cnt++; if (outa0 !== 32'h0000ABCD) $display("FAIL ldlz: got %h want %h", outa0, 32'h0000ABCD); else pass_cnt++;
        op(8'h00, 3'b001, 32'h0);
        sel(3'd2, 3'd2);
        total_cnt++; if (outa0 !== 32'hFFFFAAAA) $display("FAIL en_off_hold: got %h want %h", outa0, 32'hFFFFAAAA); else pass_cnt++;
        op(8'h30, 3'b010, 32'h00000055);
        sel(3'd4, 3'd5);
        total_cnt++; if (outa0 !== 32'h55 || outb0 !== 32'h55) $display("FAIL multi_en: got %h %h want 55 55", outa0, outb0); else pass_cnt++;
    endtask

    task automatic test_swap();
        op(8'h02, 3'b010, 32'h11);
        op(8'h08, 3'b010, 32'h33);
        sel(3'd1, 3'd3);
        swa = 3'd1; swb = 3'd3; swv = 1'b1;
        #1;
        total_cnt++; if (ready0 !== 1'b1) $display("FAIL swap_ready_idle: got %b want 1", ready0); else pass_cnt++;
        tick();
        swv = 1'b0;
        #1;
        total_cnt++; if (ready0 !== 1'b0 || done0 !== 1'b0) $display("FAIL swap_commit_st: ready %b done %b want 0 0", ready0, done0); else pass_cnt++;
        total_cnt++; if (outa0 !== 32'h11) $display("FAIL swap_early: got %h want %h", outa0, 32'h11); else pass_cnt++;
        tick();
        total_cnt++; if (done0 !== 1'b1 || ready0 !== 1'b1) $display("FAIL swap_done: done %b ready %b want 1 1", done0, ready0); else pass_cnt++;
        total_cnt++; if (outa0 !== 32'h33 || outb0 !== 32'h11) $display("FAIL swap_vals: got %h %h want 33 11", outa0, outb0); else pass_cnt++;
        total_cnt++; if (outa1 !== 32'h33 || outb1 !== 32'h11) $display("FAIL swap_vals_dut1: got %h %h want 33 11", outa1, outb1); else pass_cnt++;
        tick();
        total_cnt++; if (done0 !== 1'b0) $display("FAIL swap_done_pulse: got %b want 0", done0); else pass_cnt++;
    endtask

    task automatic test_swap_override();
        op(8'h02, 3'b010, 32'h11);
        op(8'h08, 3'b010, 32'h33);
        swa = 3'd1; swb = 3'd3; swv = 1'b1;
        tick();
        swv = 1'b0;
        op(8'h12, 3'b010, 32'h99);
        sel(3'd1, 3'd4);
        total_cnt++; if (outa0 !== 32'h33) $display("FAIL ovr_swap_wins: got %h want %h", outa0, 32'h33); else pass_cnt++;
        total_cnt++; if (outb0 !== 32'h99) $display("FAIL ovr_other_load: got %h want %h", outb0, 32'h99); else pass_cnt++;
        sel(3'd3, 3'd3);
        total_cnt++; if (outa0 !== 32'h11) $display("FAIL ovr_r3: got %h want %h", outa0, 32'h11); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        swa = 3'd1; swb = 3'd4; swv = 1'b1;
        tick();
        tick();
        sel(3'd1, 3'd4);
        total_cnt++; if (outa0 !== 32'h99 || outb0 !== 32'h33) $display("FAIL b2b_first: got %h %h want 99 33", outa0, outb0); else pass_cnt++;
        total_cnt++; if (done0 !== 1'b1 || ready0 !== 1'b1) $display("FAIL b2b_ready: done %b ready %b want 1 1", done0, ready0); else pass_cnt++;
        tick();
        swv = 1'b0;
        #1;
        total_cnt++; if (ready0 !== 1'b0 || done0 !== 1'b0) $display("FAIL b2b_accept: ready %b done %b want 0 0", ready0, done0); else pass_cnt++;
        tick();
        sel(3'd1, 3'd4);
        total_cnt++; if (outa0 !== 32'h33 || outb0 !== 32'h99 || done0 !== 1'b1) $display("FAIL b2b_second: got %h %h done %b want 33 99 1", outa0, outb0, done0); else pass_cnt++;
    endtask

    task automatic test_range();
        op(8'h80, 3'b010, 32'h77);
        sel(3'd7, 3'd7);
        total_cnt++; if (outa0 !== 32'h77) $display("FAIL r7_dut0: got %h want %h", outa0, 32'h77); else pass_cnt++;
        total_cnt++; if (outa1 !== 32'h0) $display("FAIL sel_oob: got %h want %h", outa1, 32'h0); else pass_cnt++;
        swa = 3'd2; swb = 3'd2; swv = 1'b1;
        tick();
        swv = 1'b0;
        tick();
        sel(3'd2, 3'd2);
        total_cnt++; if (done0 !== 1'b1 || done1 !== 1'b1) $display("FAIL self_swap_done: got %b%b want 11", done0, done1); else pass_cnt++;
        total_cnt++; if (outa0 !== 32'hFFFFAAAA || outa1 !== 32'hFFFFAAAA) $display("FAIL self_swap_val: got %h %h want FFFFAAAA", outa0, outa1); else pass_cnt++;
        swa = 3'd1; swb = 3'd7; swv = 1'b1;
        tick();
        swv = 1'b0;
        tick();
        sel(3'd1, 3'd7);
        total_cnt++; if (outa0 !== 32'h77 || outb0 !== 32'h33) $display("FAIL swap_r7_dut0: got %h %h want 77 33", outa0, outb0); else pass_cnt++;
        total_cnt++; if (outa1 !== 32'h0 || done1 !== 1'b1) $display("FAIL swap_oob_dut1: got %h done %b want 0 1", outa1, done1); else pass_cnt++;
    endtask

    task automatic test_reset_mid_swap();
        swa = 3'd1; swb = 3'd3; swv = 1'b1;
        tick();
        swv = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (ready0 !== 1'b1 || ready1 !== 1'b1) $display("FAIL rst_mid_ready: got %b%b want 11", ready0, ready1); else pass_cnt++;
        sel(3'd1, 3'd3);
        total_cnt++; if (outa0 !== 32'h0 || outb0 !== 32'h0) $display("FAIL rst_mid_regs: got %h %h want 0 0", outa0, outb0); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (done0 !== 1'b0 || done1 !== 1'b0) $display("FAIL rst_mid_nodone: got %b%b want 00", done0, done1); else pass_cnt++;
        total_cnt++; if (outa0 !== 32'h0 || outb0 !== 32'h0) $display("FAIL rst_mid_nocommit: got %h %h want 0 0", outa0, outb0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_bypass();
        test_functions();
        test_swap();
        test_swap_override();
        test_back_to_back();
        test_range();
        test_reset_mid_swap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
